// File: rtl/if_id_stage_pkg.sv
// IF/ID stage shared definitions.
// State encoding, opcodes and boot constants.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [5:0]  OP_LW    = 6'h23;

  localparam logic [31:0] NOP          = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h00400000;

  // rt is read as a source only by these opcodes
  function automatic logic rt_is_src(input logic [5:0] op);
    logic r;
    r = 1'b0;
    unique case (op)
      OP_RTYPE, OP_BEQ,
      OP_BNE, OP_SW: r = 1'b1;
      OP_LW:         r = 1'b0;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/if_id_stage_hazard.sv
// Load-use hazard comparator.
// Purely combinational.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic [31:0] IFID_instr,
  input  logic        IFID_valid,
  input  logic        MemRead_EX,
  input  logic [4:0]  rt_EX,
  output logic        hazard
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_low;

  assign op = IFID_instr[31:26];
  assign rs = IFID_instr[25:21];
  assign rt = IFID_instr[20:16];
  assign unused_low = ^IFID_instr[15:0];

  // load in EX writes a register the decoded word reads
  always_comb begin
    hazard = IFID_valid && MemRead_EX
          && (rt_EX != 5'd0)
          && ((rt_EX == rs)
           || (rt_is_src(op) && (rt_EX == rt)));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with boot,
// load-use stall, flush and freeze control.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      PC_sum,
  input  logic [31:0]      Instrucction,
  input  logic             jump_taken,
  input  logic             ext_stall,
  input  logic             MemRead_EX,
  input  logic [4:0]       rt_EX,
  output logic [31:0]      IFID_PC_sum,
  output logic [31:0]      IFID_instr,
  output logic             IFID_valid,
  output logic             PC_hold,
  output logic             bubble_ID,
  output logic [CNT_W-1:0] stall_count
);

  state_t state;
  logic   hazard;
  logic   flush;
  logic   stall_now;
  logic   boot;

  hazard_detect u_hazard (
    .IFID_instr (IFID_instr),
    .IFID_valid (IFID_valid),
    .MemRead_EX (MemRead_EX),
    .rt_EX      (rt_EX),
    .hazard     (hazard)
  );

  // freeze wins, then flush, then hazard
  always_comb begin
    boot      = (state == BOOT);
    flush     = jump_taken && !ext_stall;
    stall_now = (state == RUN) && hazard
             && !flush && !ext_stall;
    PC_hold   = ext_stall
             || (!flush && (boot || stall_now));
    bubble_ID = ext_stall || boot || stall_now;
  end

  // state, IFID register and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      IFID_instr  <= NOP;
      IFID_valid  <= 1'b0;
      IFID_PC_sum <= RESET_PC + 32'd4;
      stall_count <= '0;
    end else if (ext_stall) begin
      state <= state;
    end else if (flush) begin
      state       <= RUN;
      IFID_instr  <= NOP;
      IFID_valid  <= 1'b0;
      IFID_PC_sum <= PC_sum;
    end else if (stall_now) begin
      state <= STALL;
      if (stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end else begin
      state       <= RUN;
      IFID_instr  <= Instrucction;
      IFID_valid  <= 1'b1;
      IFID_PC_sum <= PC_sum;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage.
// Second instance uses a 2-bit counter.
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_sum;
  logic [31:0] instr;
  logic        jump;
  logic        ext;
  logic        mr;
  logic [4:0]  rt_ex;

  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_valid;
  logic        o_hold;
  logic        o_bub;
  logic [15:0] o_cnt;

  logic [31:0] o2_pc;
  logic [31:0] o2_instr;
  logic        o2_valid;
  logic        o2_hold;
  logic        o2_bub;
  logic [1:0]  o2_cnt;

  int tests;
  int fails;

  if_id_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_sum       (pc_sum),
    .Instrucction (instr),
    .jump_taken   (jump),
    .ext_stall    (ext),
    .MemRead_EX   (mr),
    .rt_EX        (rt_ex),
    .IFID_PC_sum  (o_pc),
    .IFID_instr   (o_instr),
    .IFID_valid   (o_valid),
    .PC_hold      (o_hold),
    .bubble_ID    (o_bub),
    .stall_count  (o_cnt)
  );

  if_id_stage #(.CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_sum       (pc_sum),
    .Instrucction (instr),
    .jump_taken   (jump),
    .ext_stall    (ext),
    .MemRead_EX   (mr),
    .rt_EX        (rt_ex),
    .IFID_PC_sum  (o2_pc),
    .IFID_instr   (o2_instr),
    .IFID_valid   (o2_valid),
    .PC_hold      (o2_hold),
    .bubble_ID    (o2_bub),
    .stall_count  (o2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jmp;
    logic        ext;
    logic        mr;
    logic [4:0]  rt;
    logic [31:0] pc;
    logic [31:0] in;
    logic        ehold;
    logic        ebub;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        evalid;
    int          ecnt;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] A   = 32'h012A4020;
  localparam logic [31:0] B   = 32'h00851020;
  localparam logic [31:0] LW  = 32'h8D2A0000;
  localparam logic [31:0] BEQ = 32'h10090000;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic j, input logic e,
                       input logic m, input logic [4:0] r,
                       input logic [31:0] p,
                       input logic [31:0] i);
    jump   = j;
    ext    = e;
    mr     = m;
    rt_ex  = r;
    pc_sum = p;
    instr  = i;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " instr"}, o_instr, 32'h0);
    chk({tag, " valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, " pc"}, o_pc, 32'h00400004);
    chk({tag, " cnt"}, {16'b0, o_cnt}, 32'd0);
    chk({tag, " cnt2"}, {30'b0, o2_cnt}, 32'd0);
    chk({tag, " hold"}, {31'b0, o_hold}, 32'd1);
    chk({tag, " bub"}, {31'b0, o_bub}, 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0);

    //        j e m rt pc      in   hold bub einstr epc   v cnt
    tbl.push_back('{0,0,0, 0,32'h100,A,  1,1,A,  32'h100,1,0});
    tbl.push_back('{0,0,1, 9,32'h104,B,  1,1,A,  32'h100,1,1});
    tbl.push_back('{0,0,0, 0,32'h104,B,  0,0,B,  32'h104,1,1});
    tbl.push_back('{0,0,1, 0,32'h108,LW, 0,0,LW, 32'h108,1,1});
    tbl.push_back('{0,0,1,10,32'h10C,A,  0,0,A,  32'h10C,1,1});
    tbl.push_back('{1,0,1,10,32'h110,B,  0,0,0,  32'h110,0,1});
    tbl.push_back('{0,0,1, 9,32'h114,A,  0,0,A,  32'h114,1,1});
    tbl.push_back('{1,1,0, 0,32'h118,B,  1,1,A,  32'h114,1,1});
    tbl.push_back('{1,1,0, 0,32'h118,B,  1,1,A,  32'h114,1,1});
    tbl.push_back('{1,1,0, 0,32'h118,B,  1,1,A,  32'h114,1,1});
    tbl.push_back('{1,0,0, 0,32'h118,B,  0,0,0,  32'h118,0,1});
    tbl.push_back('{0,0,0, 0,32'h11C,A,  0,0,A,  32'h11C,1,1});
    tbl.push_back('{0,0,1, 9,32'h120,BEQ,1,1,A,  32'h11C,1,2});
    tbl.push_back('{0,0,1, 9,32'h120,BEQ,0,0,BEQ,32'h120,1,2});
    tbl.push_back('{0,0,1, 9,32'h124,A,  1,1,BEQ,32'h120,1,3});
    tbl.push_back('{0,0,0, 0,32'h124,A,  0,0,A,  32'h124,1,3});
    tbl.push_back('{0,0,1, 9,32'h128,B,  1,1,A,  32'h124,1,4});
    tbl.push_back('{0,1,0, 0,32'h12C,B,  1,1,A,  32'h124,1,4});
    tbl.push_back('{0,0,1, 9,32'h12C,A,  0,0,A,  32'h12C,1,4});

    #7;
    chk_reset("por");

    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      string t;
      t = $sformatf("v%0d", k);
      drive(tbl[k].jmp, tbl[k].ext, tbl[k].mr,
            tbl[k].rt, tbl[k].pc, tbl[k].in);
      #2;
      chk({t, " hold"}, {31'b0, o_hold},
          {31'b0, tbl[k].ehold});
      chk({t, " bub"}, {31'b0, o_bub},
          {31'b0, tbl[k].ebub});
      @(posedge clk);
      #1;
      chk({t, " instr"}, o_instr, tbl[k].einstr);
      chk({t, " pc"}, o_pc, tbl[k].epc);
      chk({t, " valid"}, {31'b0, o_valid},
          {31'b0, tbl[k].evalid});
      chk({t, " cnt"}, {16'b0, o_cnt},
          tbl[k].ecnt);
      chk({t, " cnt2"}, {30'b0, o2_cnt},
          (tbl[k].ecnt > 3) ? 3 : tbl[k].ecnt);
      @(negedge clk);
    end

    // enter STALL, then reset mid-cycle
    drive(0, 0, 1, 9, 32'h130, B);
    @(posedge clk);
    #1;
    chk("stall hold", {31'b0, o_hold}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("mid");

    @(negedge clk);
    drive(0, 0, 0, 0, 32'h200, B);
    rst_n = 1'b1;
    #2;
    chk("boot hold", {31'b0, o_hold}, 32'd1);
    chk("boot bub", {31'b0, o_bub}, 32'd1);
    @(posedge clk);
    #1;
    chk("boot instr", o_instr, B);
    chk("boot pc", o_pc, 32'h200);
    chk("boot valid", {31'b0, o_valid}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h204, A);
    #2;
    chk("run hold", {31'b0, o_hold}, 32'd0);
    chk("run bub", {31'b0, o_bub}, 32'd0);
    chk("run cnt", {16'b0, o_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
